pipelined_ripple_adder: RTL and testbench

//  Parametrised successor of the 4-bit ripple adder: DATA_WIDTH-bit add with carry-in, split into

---
 rtl/pipelined_ripple_adder_pkg.sv | 18 +
 rtl/pipelined_ripple_adder_chunk.sv | 32 +++
 rtl/pipelined_ripple_adder.sv | 132 +++++++++++++
 tb/tb_pipelined_ripple_adder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared definitions for the pipelined ripple adder: default geometry,
// chunk-width helper and the single-bit full-adder cell used by every chunk.
package pipelined_ripple_adder_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_STAGES     = 4;

  // Width of the slice of the operands each pipeline stage adds.
  function automatic int chunk_width(input int data_width, input int stages);
    return data_width / stages;
  endfunction

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/pipelined_ripple_adder_chunk.sv
// Combinational ripple-carry adder for one chunk of the pipelined adder.
// Also exposes the carry into the chunk's top bit so the final stage can
// derive signed overflow.
module ripple_chunk_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [WIDTH:0] c;

  // Ripple the carry through a chain of full-adder cells, LSB first.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < WIDTH; i++) begin
      {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
    end
  end

  assign co    = c[WIDTH];
  assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// DATA_WIDTH-bit adder with carry-in split into STAGES chunk stages, one
// register stage per chunk, with streaming valid/ready on both sides.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are 1. Stage k is ready when it is empty or its successor
// is ready (rd_k = !vld_k | rd_{k+1}, the last stage uses out_rd), so
// empty stages always accept and bubbles collapse behind a stalled output.
// Valid never depends on ready; data and flags hold while not ready.
//
// Each stage register carries a single operand-a vector whose lower
// (already processed) chunks have been overwritten with sum bits, the
// operand-b vector, the chunk carry and the valid flag.
module pipelined_ripple_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int STAGES     = DEFAULT_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_ci,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] out_s,
  output logic                  out_co,
  output logic                  out_ovf,
  output logic                  out_vld,
  input  logic                  out_rd
);

  localparam int CHUNK = chunk_width(DATA_WIDTH, STAGES);

  if (STAGES < 1 || (DATA_WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_ripple_adder: DATA_WIDTH must be divisible by STAGES and STAGES >= 1");
  end

  // Stage registers (index k = output register of stage k)
  logic [DATA_WIDTH-1:0] sa_q [STAGES];
  logic [DATA_WIDTH-1:0] b_q  [STAGES];
  logic [STAGES-1:0]     c_q;
  logic [STAGES-1:0]     vld_q;
  logic                  ovf_q;

  // Stage inputs, adder results and ready chain
  logic [DATA_WIDTH-1:0] sa_in  [STAGES];
  logic [DATA_WIDTH-1:0] b_in   [STAGES];
  logic [DATA_WIDTH-1:0] sa_nxt [STAGES];
  logic [STAGES-1:0]     c_in;
  logic [STAGES-1:0]     vld_in;
  logic [STAGES-1:0]     rd;
  logic [CHUNK-1:0]      ch_s   [STAGES];
  logic [STAGES-1:0]     ch_co;
  logic                  ch_cmsb [STAGES];

  // Stage 0 takes the input port; every later stage takes its predecessor's registers.
  always_comb begin
    sa_in[0]  = in_a;
    b_in[0]   = in_b;
    c_in      = '0;
    vld_in    = '0;
    c_in[0]   = in_ci;
    vld_in[0] = in_vld;
    for (int k = 1; k < STAGES; k++) begin
      sa_in[k]  = sa_q[k-1];
      b_in[k]   = b_q[k-1];
      c_in[k]   = c_q[k-1];
      vld_in[k] = vld_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ripple_chunk_adder #(.WIDTH(CHUNK)) u_chunk (
      .a     (sa_in[k][k*CHUNK +: CHUNK]),
      .b     (b_in[k][k*CHUNK +: CHUNK]),
      .ci    (c_in[k]),
      .s     (ch_s[k]),
      .co    (ch_co[k]),
      .c_msb (ch_cmsb[k])
    );
  end

  // Splice each chunk sum into the forwarded operand-a vector.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sa_nxt[k]                    = sa_in[k];
      sa_nxt[k][k*CHUNK +: CHUNK]  = ch_s[k];
    end
  end

  // Ready chain from the output back to the input.
  always_comb begin
    rd             = '0;
    rd[STAGES-1]   = !vld_q[STAGES-1] | out_rd;
    for (int k = STAGES - 2; k >= 0; k--) begin
      rd[k] = !vld_q[k] | rd[k+1];
    end
  end

  // Stage registers: load whenever the stage is ready, clear everything on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sa_q[k] <= '0;
        b_q[k]  <= '0;
      end
      c_q   <= '0;
      vld_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rd[k]) begin
          sa_q[k]  <= sa_nxt[k];
          b_q[k]   <= b_in[k];
          c_q[k]   <= ch_co[k];
          vld_q[k] <= vld_in[k];
        end
      end
      if (rd[STAGES-1]) begin
        ovf_q <= ch_cmsb[STAGES-1] ^ ch_co[STAGES-1];
      end
    end
  end

  assign in_rd   = rd[0];
  assign out_s   = sa_q[STAGES-1];
  assign out_co  = c_q[STAGES-1];
  assign out_ovf = ovf_q;
  assign out_vld = vld_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: default 32/4 instance with a scoreboard,
// plus 32/1 and 8/8 instances for latency, one-entry and reset behaviour.
module tb_pipelined_ripple_adder;

  localparam int W = 32;
  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic [W-1:0] a, b, out_s;
  logic         ci, in_vld, in_rd, out_co, out_ovf, out_vld, out_rd;

  logic [W-1:0] s1_a, s1_b, s1_out_s;
  logic         s1_ci, s1_in_vld, s1_in_rd, s1_out_co, s1_out_ovf, s1_out_vld, s1_out_rd;

  logic [7:0]   s8_a, s8_b, s8_out_s;
  logic         s8_ci, s8_in_vld, s8_in_rd, s8_out_co, s8_out_ovf, s8_out_vld, s8_out_rd;

  pipelined_ripple_adder #(.DATA_WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_a(a), .in_b(b), .in_ci(ci), .in_vld(in_vld), .in_rd(in_rd),
    .out_s(out_s), .out_co(out_co), .out_ovf(out_ovf), .out_vld(out_vld), .out_rd(out_rd));

  pipelined_ripple_adder #(.DATA_WIDTH(W), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_a(s1_a), .in_b(s1_b), .in_ci(s1_ci), .in_vld(s1_in_vld),
    .in_rd(s1_in_rd), .out_s(s1_out_s), .out_co(s1_out_co), .out_ovf(s1_out_ovf),
    .out_vld(s1_out_vld), .out_rd(s1_out_rd));

  pipelined_ripple_adder #(.DATA_WIDTH(8), .STAGES(8)) dut_s8 (
    .clk(clk), .rst_n(rst_n), .in_a(s8_a), .in_b(s8_b), .in_ci(s8_ci), .in_vld(s8_in_vld),
    .in_rd(s8_in_rd), .out_s(s8_out_s), .out_co(s8_out_co), .out_ovf(s8_out_ovf),
    .out_vld(s8_out_vld), .out_rd(s8_out_rd));

  // ---------------- scoreboard state ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int emitted  = 0;
  bit rand_rd  = 1'b0;
  logic [W+1:0] exp_q[$];   // {ovf, co, sum}

  // Reference: wide add, overflow from operand/result sign bits.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         ovf;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    s    = full[W-1:0];
    ovf  = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {ovf, full[W], s};
  endfunction

  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] full;
    logic       ovf;
    full = {1'b0, x} + {1'b0, y} + {8'd0, c};
    ovf  = (x[7] == y[7]) && (full[7] != x[7]);
    return {ovf, full[8], full[7:0]};
  endfunction

  // Output monitor: every emitted beat of the main DUT must match the queue head.
  always @(negedge clk) begin : mon
    logic [W+1:0] got_v, exp_v;
    #2;
    if (rst_n && out_vld && out_rd) begin
      got_v = {out_ovf, out_co, out_s};
      emitted++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_beat: got %h, required no output", got_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) $display("FAIL scoreboard: got %h, required %h", got_v, exp_v);
        else pass_cnt++;
      end
    end
  end

  // Random downstream ready when enabled.
  always @(negedge clk) begin
    if (rand_rd) out_rd = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, output int waits);
    waits = 0;
    @(negedge clk);
    a = x; b = y; ci = c; in_vld = 1'b1;
    #1;
    while (!in_rd && waits < 1000) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (in_rd) exp_q.push_back(model(x, y, c));
    else begin
      chk_cnt++;
      $display("FAIL send_timeout: in_rd=%b, required 1", in_rd);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      in_vld = 1'b0;
      t++;
    end
    #3;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d beats left, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_cnt++; if (out_vld !== 1'b0) $display("FAIL rst_out_vld: got %b, required 0", out_vld); else pass_cnt++;
    chk_cnt++; if (out_s !== '0) $display("FAIL rst_out_s: got %h, required 0", out_s); else pass_cnt++;
    chk_cnt++; if ({out_co, out_ovf} !== 2'b00) $display("FAIL rst_co_ovf: got %b%b, required 00", out_co, out_ovf); else pass_cnt++;
    chk_cnt++; if (in_rd !== 1'b1) $display("FAIL rst_in_rd: got %b, required 1", in_rd); else pass_cnt++;
    chk_cnt++; if ({s1_out_vld, s1_in_rd, s8_out_vld, s8_in_rd} !== 4'b0101) $display("FAIL rst_small: got %b, required 0101", {s1_out_vld, s1_in_rd, s8_out_vld, s8_in_rd}); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] tb [5] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W+1:0] te [5] = '{{2'b01, 32'h0}, {2'b10, 32'h8000_0000}, {2'b11, 32'h0}, {2'b00, 32'h1}, {2'b01, 32'h0}};
    int w;
    out_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(ta[i], tb[i], tc[i], w);
      repeat (S - 1) begin
        @(negedge clk);
        in_vld = 1'b0;
      end
      #1;
      chk_cnt++; if (out_vld !== 1'b0) $display("FAIL latency_early[%0d]: out_vld=%b, required 0", i, out_vld); else pass_cnt++;
      @(negedge clk);
      #1;
      chk_cnt++;
      if ({out_vld, out_ovf, out_co, out_s} !== {1'b1, te[i]})
        $display("FAIL directed[%0d]: got vld=%b %h, required vld=1 %h", i, out_vld, {out_ovf, out_co, out_s}, te[i]);
      else pass_cnt++;
    end
    drain();
  endtask

  task automatic test_stream();
    int w, stalls = 0, e0 = emitted;
    out_rd = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), w);
      stalls += w;
    end
    drain();
    chk_cnt++; if (stalls != 0) $display("FAIL stream_stalls: got %0d, required 0", stalls); else pass_cnt++;
    chk_cnt++; if (emitted - e0 != 100) $display("FAIL stream_count: got %0d, required 100", emitted - e0); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int acc = 0, e0 = emitted;
    logic [W-1:0] x, y;
    logic         c;
    out_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1));
      a = x; b = y; ci = c; in_vld = 1'b1;
      #1;
      if (in_rd) begin
        exp_q.push_back(model(x, y, c));
        acc++;
      end
      if (i >= 4 && exp_q.size() > 0) begin
        chk_cnt++;
        if ({out_vld, out_s} !== {1'b1, exp_q[0][W-1:0]})
          $display("FAIL held_out_s[%0d]: got vld=%b %h, required vld=1 %h", i, out_vld, out_s, exp_q[0][W-1:0]);
        else pass_cnt++;
      end
    end
    chk_cnt++; if (acc != S) $display("FAIL bp_accepted: got %0d, required %0d", acc, S); else pass_cnt++;
    chk_cnt++; if (in_rd !== 1'b0) $display("FAIL bp_in_rd: got %b, required 0", in_rd); else pass_cnt++;
    @(negedge clk);
    in_vld = 1'b0;
    out_rd = 1'b1;
    drain();
    chk_cnt++; if (emitted - e0 != S) $display("FAIL bp_emitted: got %0d, required %0d", emitted - e0, S); else pass_cnt++;
  endtask

  task automatic test_bubbles();
    int acc = 0;
    logic [W-1:0] x, y;
    out_rd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      x = $urandom; y = $urandom;
      a = x; b = y; ci = 1'b0; in_vld = (i % 3 == 0);
      #1;
      if (in_vld && in_rd) begin
        exp_q.push_back(model(x, y, 1'b0));
        acc++;
      end
    end
    chk_cnt++; if (acc != S) $display("FAIL bubble_fill: got %0d, required %0d", acc, S); else pass_cnt++;
    @(negedge clk);
    in_vld = 1'b0;
    out_rd = 1'b1;
    drain();
  endtask

  task automatic test_random();
    int acc = 0, cyc = 0, e0 = emitted;
    logic [W-1:0] x, y;
    logic         c;
    rand_rd = 1'b1;
    while (acc < 1000 && cyc < 20000) begin
      @(negedge clk);
      x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1));
      a = x; b = y; ci = c; in_vld = 1'($urandom_range(0, 1));
      #1;
      if (in_vld && in_rd) begin
        exp_q.push_back(model(x, y, c));
        acc++;
      end
      cyc++;
    end
    @(negedge clk);
    rand_rd = 1'b0;
    out_rd  = 1'b1;
    in_vld  = 1'b0;
    drain();
    chk_cnt++; if (acc != 1000) $display("FAIL random_accepted: got %0d, required 1000", acc); else pass_cnt++;
    chk_cnt++; if (emitted - e0 != 1000) $display("FAIL random_emitted: got %0d, required 1000", emitted - e0); else pass_cnt++;
  endtask

  task automatic test_small_configs();
    logic [W-1:0] x, y;
    logic [7:0]   x8, y8;
    logic         c;
    s1_out_rd = 1'b1;
    s8_out_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = (i == 0) ? 32'h7FFF_FFFF : $urandom;
      y = (i == 0) ? 32'h1 : $urandom;
      c = 1'($urandom_range(0, 1));
      @(negedge clk);
      s1_a = x; s1_b = y; s1_ci = (i == 0) ? 1'b0 : c; s1_in_vld = 1'b1;
      #1;
      chk_cnt++; if (s1_in_rd !== 1'b1) $display("FAIL s1_in_rd[%0d]: got %b, required 1", i, s1_in_rd); else pass_cnt++;
      @(negedge clk);
      s1_in_vld = 1'b0;
      #1;
      chk_cnt++;
      if ({s1_out_vld, s1_out_ovf, s1_out_co, s1_out_s} !== {1'b1, model(x, y, s1_ci)})
        $display("FAIL s1_result[%0d]: got %h, required %h", i, {s1_out_vld, s1_out_ovf, s1_out_co, s1_out_s}, {1'b1, model(x, y, s1_ci)});
      else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      x8 = (i == 0) ? 8'h7F : 8'($urandom);
      y8 = (i == 0) ? 8'h01 : 8'($urandom);
      c  = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      s8_a = x8; s8_b = y8; s8_ci = c; s8_in_vld = 1'b1;
      repeat (7) begin
        @(negedge clk);
        s8_in_vld = 1'b0;
      end
      #1;
      chk_cnt++; if (s8_out_vld !== 1'b0) $display("FAIL s8_latency_early[%0d]: got %b, required 0", i, s8_out_vld); else pass_cnt++;
      @(negedge clk);
      #1;
      chk_cnt++;
      if ({s8_out_vld, s8_out_ovf, s8_out_co, s8_out_s} !== {1'b1, model8(x8, y8, c)})
        $display("FAIL s8_result[%0d]: got %h, required %h", i, {s8_out_vld, s8_out_ovf, s8_out_co, s8_out_s}, {1'b1, model8(x8, y8, c)});
      else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_rd = 1'b0; s1_out_rd = 1'b0; s8_out_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; ci = 1'b1; in_vld = 1'b1;
      s1_a = $urandom; s1_b = $urandom; s1_ci = 1'b1; s1_in_vld = 1'b1;
      s8_a = 8'($urandom); s8_b = 8'($urandom); s8_ci = 1'b1; s8_in_vld = 1'b1;
    end
    @(negedge clk);
    #1;
    chk_cnt++; if (s1_in_rd !== 1'b0) $display("FAIL s1_full_in_rd: got %b, required 0", s1_in_rd); else pass_cnt++;
    in_vld = 1'b0; s1_in_vld = 1'b0; s8_in_vld = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_cnt++;
    if ({out_vld, out_co, out_ovf, in_rd, out_s} !== {4'b0001, {W{1'b0}}})
      $display("FAIL midrst_main: got %b %h, required 0001 0", {out_vld, out_co, out_ovf, in_rd}, out_s);
    else pass_cnt++;
    chk_cnt++;
    if ({s1_out_vld, s1_in_rd, s1_out_s, s8_out_vld, s8_in_rd, s8_out_s} !== {2'b01, {W{1'b0}}, 2'b01, 8'h00})
      $display("FAIL midrst_small: got %b%b %h %b%b %h, required 01 0 01 0", s1_out_vld, s1_in_rd, s1_out_s, s8_out_vld, s8_in_rd, s8_out_s);
    else pass_cnt++;
    out_rd = 1'b1; s1_out_rd = 1'b1; s8_out_rd = 1'b1;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (out_vld || s1_out_vld || s8_out_vld) seen++;
    end
    chk_cnt++; if (seen != 0) $display("FAIL midrst_ghost: %0d cycles with output, required 0", seen); else pass_cnt++;
  endtask

  // ---------------- sequencing / report ----------------
  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; ci = 1'b0; in_vld = 1'b0; out_rd = 1'b0;
    s1_a = '0; s1_b = '0; s1_ci = 1'b0; s1_in_vld = 1'b0; s1_out_rd = 1'b0;
    s8_a = '0; s8_b = '0; s8_ci = 1'b0; s8_in_vld = 1'b0; s8_out_rd = 1'b0;
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_bubbles();
    test_random();
    test_small_configs();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
